// File: rtl/speed_ctrl_pkg.sv
// Shared types and constants for the speed controller.
// Holds the FSM state enum, speed width, divider limit and gear thresholds.
package speed_ctrl_pkg;

  localparam int ACCEL_W = 25;
  localparam logic [ACCEL_W-1:0] CLK_DIV_LIMIT = 25'h17D7840;
  localparam logic [ACCEL_W-1:0] GEAR1_TH = 25'd8000000;
  localparam logic [ACCEL_W-1:0] GEAR2_TH = 25'd16000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCEL = 2'd1,
    BRAKE = 2'd2,
    COAST = 2'd3
  } state_t;

  function automatic logic [1:0] gear_of(input logic [ACCEL_W-1:0] v,
                                         input logic [ACCEL_W-1:0] th1,
                                         input logic [ACCEL_W-1:0] th2,
                                         input logic [ACCEL_W-1:0] vmax);
    logic [1:0] g;
    if (v == vmax)    g = 2'd3;
    else if (v < th1) g = 2'd0;
    else if (v < th2) g = 2'd1;
    else              g = 2'd2;
    return g;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Level debouncer: output follows input only after DEBOUNCE_CYCLES stable cycles.
// Any input change reloads the down-counter.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_last <= 1'b0;
      r_out  <= 1'b0;
    end else if (in != r_last) begin
      r_last <= in;
      r_cnt  <= CW'(DEBOUNCE_CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_out <= r_last;
    end
  end

  assign out = r_out;

endmodule

// File: rtl/speed_controller.sv
// Button-driven speed ramp: accelerate/brake/coast a saturating offset once per tick.
// Define SPEED_CTRL_DEBOUNCE_EN to insert btn_debounce after each synchronizer.
module speed_controller
  import speed_ctrl_pkg::*;
#(
  parameter int TICK_DIV        = 5000000,
  parameter int STEP_ACCEL      = 200000,
  parameter int STEP_BRAKE      = 500000,
  parameter int STEP_COAST      = 50000,
  parameter int ACCEL_MAX       = 24000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int GEAR1_LIMIT     = int'(GEAR1_TH),
  parameter int GEAR2_LIMIT     = int'(GEAR2_TH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_accel,
  input  logic               btn_brake,
  output logic [ACCEL_W-1:0] acelerator,
  output logic [1:0]         gear,
  output logic               upd
);

  localparam logic [ACCEL_W-1:0] L_MAX   = ACCEL_W'(ACCEL_MAX);
  localparam logic [ACCEL_W-1:0] L_BRAKE = ACCEL_W'(STEP_BRAKE);
  localparam logic [ACCEL_W-1:0] L_COAST = ACCEL_W'(STEP_COAST);
  localparam logic [ACCEL_W-1:0] L_G1    = ACCEL_W'(GEAR1_LIMIT);
  localparam logic [ACCEL_W-1:0] L_G2    = ACCEL_W'(GEAR2_LIMIT);
  localparam logic [31:0]        L_TLAST = 32'(TICK_DIV - 1);

  if (ACCEL_MAX >= int'(CLK_DIV_LIMIT) || DEBOUNCE_CYCLES < 1 || TICK_DIV < 1) begin : g_cfg_err
    $error("speed_controller: invalid parameter set");
  end

  logic [1:0]         r_sync_acc;
  logic [1:0]         r_sync_brk;
  logic               w_acc_d;
  logic               w_brk_d;
  logic [31:0]        r_tick_cnt;
  logic               w_tick;
  state_t             r_state;
  state_t             w_next_state;
  logic [ACCEL_W-1:0] r_acc;
  logic [ACCEL_W-1:0] w_new;
  logic [ACCEL_W:0]   w_sum;
  logic [1:0]         r_gear;
  logic               r_upd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_acc <= '0;
      r_sync_brk <= '0;
    end else begin
      r_sync_acc <= {r_sync_acc[0], btn_accel};
      r_sync_brk <= {r_sync_brk[0], btn_brake};
    end
  end

`ifdef SPEED_CTRL_DEBOUNCE_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_acc (
    .clk(clk), .rst(rst), .in(r_sync_acc[1]), .out(w_acc_d)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_brk (
    .clk(clk), .rst(rst), .in(r_sync_brk[1]), .out(w_brk_d)
  );
`else
  assign w_acc_d = r_sync_acc[1];
  assign w_brk_d = r_sync_brk[1];
`endif

  assign w_tick = (r_tick_cnt == L_TLAST);

  always_ff @(posedge clk) begin
    if (rst || w_tick) r_tick_cnt <= '0;
    else               r_tick_cnt <= r_tick_cnt + 32'd1;
  end

  // Brake dominates accelerate when both are held.
  always_comb begin
    w_next_state = IDLE;
    if (w_brk_d)            w_next_state = BRAKE;
    else if (w_acc_d)       w_next_state = ACCEL;
    else if (r_acc != '0)   w_next_state = COAST;
  end

  assign w_sum = {1'b0, r_acc} + (ACCEL_W+1)'(STEP_ACCEL);

  always_comb begin
    w_new = r_acc;
    case (r_state)
      ACCEL:   w_new = (w_sum >= {1'b0, L_MAX}) ? L_MAX : w_sum[ACCEL_W-1:0];
      BRAKE:   w_new = (r_acc >= L_BRAKE) ? r_acc - L_BRAKE : '0;
      COAST:   w_new = (r_acc >= L_COAST) ? r_acc - L_COAST : '0;
      default: w_new = r_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_gear  <= 2'd0;
      r_upd   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_upd   <= 1'b0;
      if (w_tick && (w_new != r_acc)) begin
        r_acc  <= w_new;
        r_gear <= gear_of(w_new, L_G1, L_G2, L_MAX);
        r_upd  <= 1'b1;
      end
    end
  end

  assign acelerator = r_acc;
  assign gear       = r_gear;
  assign upd        = r_upd;

endmodule
